idu_stage: RTL and testbench

IDU_STAGE -- requirements
Module: idu_stage

---
 rtl/idu_stage.sv | 270 +++++++++++++++++++++++++++
 tb/tb_idu_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_stage.sv
// Decode stage: registers one OP / OP-IMM instruction per handshake and tallies illegal results.
// Optional flush port and behaviour are enabled by defining IDU_FLUSH_EN.
module idu_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      inst_i,
    output logic [4:0]       rs1_addr_o,
    output logic [4:0]       rs2_addr_o,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
`ifdef IDU_FLUSH_EN
    input  logic             flush_i,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      pc_o,
    output logic [XLEN-1:0]  rs1_data_o,
    output logic [XLEN-1:0]  rs2_data_o,
    output logic [XLEN-1:0]  imm_o,
    output logic [4:0]       rd_addr_o,
    output logic             rd_we_o,
    output logic             illegal_o,
    output logic [DEC_W-1:0] dec_info_bus_o,
    output logic [15:0]      illegal_cnt_o
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned OP_BITS = 20;
    localparam int unsigned IMM_W   = 12;

    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [4:0] BIT_OR      = 5'd0;
    localparam logic [4:0] BIT_ADD     = 5'd1;
    localparam logic [4:0] BIT_SUB     = 5'd2;
    localparam logic [4:0] BIT_SLL     = 5'd3;
    localparam logic [4:0] BIT_SLT     = 5'd4;
    localparam logic [4:0] BIT_SLTU    = 5'd5;
    localparam logic [4:0] BIT_XOR     = 5'd6;
    localparam logic [4:0] BIT_SRL     = 5'd7;
    localparam logic [4:0] BIT_SRA     = 5'd8;
    localparam logic [4:0] BIT_AND     = 5'd9;
    localparam logic [4:0] BIT_ADDI    = 5'd10;
    localparam logic [4:0] BIT_SLTI    = 5'd11;
    localparam logic [4:0] BIT_SLTIU   = 5'd12;
    localparam logic [4:0] BIT_XORI    = 5'd13;
    localparam logic [4:0] BIT_ORI     = 5'd14;
    localparam logic [4:0] BIT_ANDI    = 5'd15;
    localparam logic [4:0] BIT_SLLI    = 5'd16;
    localparam logic [4:0] BIT_SRLI    = 5'd17;
    localparam logic [4:0] BIT_SRAI    = 5'd18;
    localparam logic [4:0] BIT_IMM_SEL = 5'd19;

    typedef struct packed {
        logic [31:0]      pc;
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
        logic [XLEN-1:0]  imm;
        logic [4:0]       rd;
        logic             we;
        logic             ill;
        logic [DEC_W-1:0] dec;
    } result_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    result_t            res_q, res_d;
    logic [CNT_W-1:0]   cnt_q;

    logic               flush;
    logic               accept;
    logic               drain;
    logic               count_en;

    logic [4:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic               hit;
    logic               is_op_imm;
    logic [4:0]         op_idx;
    logic [OP_BITS-1:0] dec_bits;
    logic               unused_bits;

`ifdef IDU_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Opcode low bits are not part of the class decode.
    assign unused_bits = ^inst_i[1:0];

    assign rs1_addr_o = inst_i[19:15];
    assign rs2_addr_o = inst_i[24:20];

    assign out_valid_o = (state_q == ST_FULL);
    assign in_ready_o  = !flush && (!out_valid_o || out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign drain       = out_valid_o && out_ready_i;
    assign count_en    = drain && res_q.ill && !flush;

    // Instruction classification into a single one-hot operation index.
    always_comb begin
        opcode    = inst_i[6:2];
        funct3    = inst_i[14:12];
        funct7    = inst_i[31:25];
        hit       = 1'b0;
        op_idx    = BIT_OR;
        is_op_imm = (opcode == OPC_OP_IMM);
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    hit = 1'b1;
                    case (funct3)
                        3'b000:  op_idx = BIT_ADD;
                        3'b001:  op_idx = BIT_SLL;
                        3'b010:  op_idx = BIT_SLT;
                        3'b011:  op_idx = BIT_SLTU;
                        3'b100:  op_idx = BIT_XOR;
                        3'b101:  op_idx = BIT_SRL;
                        3'b110:  op_idx = BIT_OR;
                        default: op_idx = BIT_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    case (funct3)
                        3'b000: begin
                            hit    = 1'b1;
                            op_idx = BIT_SUB;
                        end
                        3'b101: begin
                            hit    = 1'b1;
                            op_idx = BIT_SRA;
                        end
                        default: hit = 1'b0;
                    endcase
                end
            end
            OPC_OP_IMM: begin
                case (funct3)
                    3'b000: begin
                        hit    = 1'b1;
                        op_idx = BIT_ADDI;
                    end
                    3'b001: begin
                        hit    = (funct7 == F7_BASE);
                        op_idx = BIT_SLLI;
                    end
                    3'b010: begin
                        hit    = 1'b1;
                        op_idx = BIT_SLTI;
                    end
                    3'b011: begin
                        hit    = 1'b1;
                        op_idx = BIT_SLTIU;
                    end
                    3'b100: begin
                        hit    = 1'b1;
                        op_idx = BIT_XORI;
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE) begin
                            hit    = 1'b1;
                            op_idx = BIT_SRLI;
                        end else if (funct7 == F7_ALT) begin
                            hit    = 1'b1;
                            op_idx = BIT_SRAI;
                        end
                    end
                    3'b110: begin
                        hit    = 1'b1;
                        op_idx = BIT_ORI;
                    end
                    default: begin
                        hit    = 1'b1;
                        op_idx = BIT_ANDI;
                    end
                endcase
            end
            default: hit = 1'b0;
        endcase

        dec_bits = '0;
        if (hit) begin
            dec_bits[op_idx]      = 1'b1;
            dec_bits[BIT_IMM_SEL] = is_op_imm;
        end
    end

    // Next result assembled from the instruction and same-cycle regfile data.
    always_comb begin
        res_d     = '0;
        res_d.pc  = pc_i;
        res_d.rs1 = rs1_data_i;
        res_d.rs2 = rs2_data_i;
        res_d.imm = is_op_imm ? {{(XLEN-IMM_W){inst_i[31]}}, inst_i[31:20]} : '0;
        res_d.rd  = inst_i[11:7];
        res_d.we  = hit && (inst_i[11:7] != 5'd0);
        res_d.ill = !hit;
        res_d.dec[OP_BITS-1:0] = dec_bits;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output slot occupancy: filled on accept, emptied on drain or flush.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (flush) begin
                    state_d = ST_EMPTY;
                end else if (out_ready_i && !accept) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
        end else if (accept) begin
            res_q <= res_d;
        end
    end

    // Saturating tally of illegal results handed downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (count_en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign pc_o           = res_q.pc;
    assign rs1_data_o     = res_q.rs1;
    assign rs2_data_o     = res_q.rs2;
    assign imm_o          = res_q.imm;
    assign rd_addr_o      = res_q.rd;
    assign rd_we_o        = res_q.we;
    assign illegal_o      = res_q.ill;
    assign dec_info_bus_o = res_q.dec;
    assign illegal_cnt_o  = cnt_q;

endmodule

// File: tb/tb_idu_stage.sv
// Directed plus randomized bench for idu_stage against a table-driven reference model.
// Flush stimulus is exercised only when IDU_FLUSH_EN is defined.
module tb_idu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic [4:0]  rs1_addr_o;
    logic [4:0]  rs2_addr_o;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] pc_o;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic [31:0] imm_o;
    logic [4:0]  rd_addr_o;
    logic        rd_we_o;
    logic        illegal_o;
    logic [19:0] dec_info_bus_o;
    logic [15:0] illegal_cnt_o;
`ifdef IDU_FLUSH_EN
    logic        flush_drv;
`endif

    idu_stage #(.XLEN(32), .DEC_W(20)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .pc_i           (pc_i),
        .inst_i         (inst_i),
        .rs1_addr_o     (rs1_addr_o),
        .rs2_addr_o     (rs2_addr_o),
        .rs1_data_i     (rs1_data_i),
        .rs2_data_i     (rs2_data_i),
`ifdef IDU_FLUSH_EN
        .flush_i        (flush_drv),
`endif
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .pc_o           (pc_o),
        .rs1_data_o     (rs1_data_o),
        .rs2_data_o     (rs2_data_o),
        .imm_o          (imm_o),
        .rd_addr_o      (rd_addr_o),
        .rd_we_o        (rd_we_o),
        .illegal_o      (illegal_o),
        .dec_info_bus_o (dec_info_bus_o),
        .illegal_cnt_o  (illegal_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  opc;
        logic [2:0]  f3;
        logic        chk7;
        logic [6:0]  f7;
        int unsigned bitn;
    } pat_t;

    pat_t        pats[$];
    logic [31:0] xfer_log[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model of the single output slot
    logic        m_valid;
    logic [31:0] m_pc, m_r1, m_r2, m_imm;
    logic [4:0]  m_rd;
    logic        m_we, m_ill;
    logic [19:0] m_bus;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic add_pat(input logic [4:0] opc, input logic [2:0] f3, input logic chk7,
                           input logic [6:0] f7, input int unsigned bitn);
        pat_t p;
        p.opc = opc; p.f3 = f3; p.chk7 = chk7; p.f7 = f7; p.bitn = bitn;
        pats.push_back(p);
    endtask

    // Legal encodings listed as (opcode, funct3, optional funct7) -> one-hot bit
    task automatic init_table();
        add_pat(5'b01100, 3'b110, 1'b1, 7'h00, 0);
        add_pat(5'b01100, 3'b000, 1'b1, 7'h00, 1);
        add_pat(5'b01100, 3'b000, 1'b1, 7'h20, 2);
        add_pat(5'b01100, 3'b001, 1'b1, 7'h00, 3);
        add_pat(5'b01100, 3'b010, 1'b1, 7'h00, 4);
        add_pat(5'b01100, 3'b011, 1'b1, 7'h00, 5);
        add_pat(5'b01100, 3'b100, 1'b1, 7'h00, 6);
        add_pat(5'b01100, 3'b101, 1'b1, 7'h00, 7);
        add_pat(5'b01100, 3'b101, 1'b1, 7'h20, 8);
        add_pat(5'b01100, 3'b111, 1'b1, 7'h00, 9);
        add_pat(5'b00100, 3'b000, 1'b0, 7'h00, 10);
        add_pat(5'b00100, 3'b010, 1'b0, 7'h00, 11);
        add_pat(5'b00100, 3'b011, 1'b0, 7'h00, 12);
        add_pat(5'b00100, 3'b100, 1'b0, 7'h00, 13);
        add_pat(5'b00100, 3'b110, 1'b0, 7'h00, 14);
        add_pat(5'b00100, 3'b111, 1'b0, 7'h00, 15);
        add_pat(5'b00100, 3'b001, 1'b1, 7'h00, 16);
        add_pat(5'b00100, 3'b101, 1'b1, 7'h00, 17);
        add_pat(5'b00100, 3'b101, 1'b1, 7'h20, 18);
    endtask

    function automatic void ref_decode(input logic [31:0] inst, output logic ill,
                                       output logic [19:0] bus, output logic [31:0] imm);
        int hit = -1;
        bus = '0;
        foreach (pats[k]) begin
            if (pats[k].opc == inst[6:2] && pats[k].f3 == inst[14:12] &&
                (!pats[k].chk7 || pats[k].f7 == inst[31:25]))
                hit = k;
        end
        ill = (hit < 0);
        if (!ill) begin
            bus[pats[hit].bitn] = 1'b1;
            if (inst[6:2] == 5'b00100) bus[19] = 1'b1;
        end
        imm = (inst[6:2] == 5'b00100) ? 32'($signed(inst[31:20])) : 32'd0;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int unsigned sel;
        w   = $urandom;
        sel = $urandom_range(0, 3);
        w[6:0] = ($urandom_range(0, 1) == 1) ? 7'b0110011 : 7'b0010011;
        if (sel == 0) w[31:25] = 7'h00;
        else if (sel == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid_o), 32'(m_valid));
        chk("illegal_cnt", 32'(illegal_cnt_o), 32'(m_cnt));
        if (m_valid) begin
            chk("pc_o", pc_o, m_pc);
            chk("rs1_data_o", rs1_data_o, m_r1);
            chk("rs2_data_o", rs2_data_o, m_r2);
            chk("imm_o", imm_o, m_imm);
            chk("rd_addr_o", 32'(rd_addr_o), 32'(m_rd));
            chk("rd_we_o", 32'(rd_we_o), 32'(m_we));
            chk("illegal_o", 32'(illegal_o), 32'(m_ill));
            chk("dec_info", 32'(dec_info_bus_o), 32'(m_bus));
        end
    endtask

    // One clock of stimulus: drive, check handshake, advance model, check registered outputs.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic ordy, input logic fl);
        logic exp_ready, drain, acc, ill;
        logic [19:0] bus;
        logic [31:0] imm;
        @(negedge clk);
        in_valid_i = v; pc_i = pc; inst_i = inst;
        rs1_data_i = d1; rs2_data_i = d2; out_ready_i = ordy;
`ifdef IDU_FLUSH_EN
        flush_drv = fl;
`endif
        #1;
        exp_ready = !fl && (!m_valid || ordy);
        chk("in_ready", 32'(in_ready_o), 32'(exp_ready));
        chk("rs1_addr", 32'(rs1_addr_o), 32'(inst[19:15]));
        chk("rs2_addr", 32'(rs2_addr_o), 32'(inst[24:20]));
        if (out_valid_o && out_ready_i && !fl) xfer_log.push_back(pc_o);
        drain = m_valid && ordy && !fl;
        acc   = v && exp_ready;
        if (drain && m_ill && m_cnt < 65535) m_cnt++;
        if (acc) begin
            ref_decode(inst, ill, bus, imm);
            m_valid = 1'b1; m_pc = pc; m_r1 = d1; m_r2 = d2; m_imm = imm;
            m_rd = inst[11:7]; m_ill = ill; m_bus = bus;
            m_we = !ill && (inst[11:7] != 5'd0);
        end else if (drain || fl) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Reset with a valid input and ready downstream so reset must win over accept.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid_i = 1'b1; inst_i = 32'h0020E1B3; pc_i = 32'hDEAD0000;
        rs1_data_i = 32'h1234; rs2_data_i = 32'h5678; out_ready_i = 1'b1;
`ifdef IDU_FLUSH_EN
        flush_drv = 1'b0;
`endif
        @(posedge clk);
        #1;
        m_valid = 1'b0; m_cnt = 0;
        m_pc = '0; m_r1 = '0; m_r2 = '0; m_imm = '0; m_rd = '0; m_we = 1'b0; m_ill = 1'b0; m_bus = '0;
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_cnt", 32'(illegal_cnt_o), 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_rs1", rs1_data_o, 32'd0);
        chk("rst_rs2", rs2_data_o, 32'd0);
        chk("rst_imm", imm_o, 32'd0);
        chk("rst_rd", 32'(rd_addr_o), 32'd0);
        chk("rst_we", 32'(rd_we_o), 32'd0);
        chk("rst_ill", 32'(illegal_o), 32'd0);
        chk("rst_dec", 32'(dec_info_bus_o), 32'd0);
        chk("rst_ready", 32'(in_ready_o), 32'd1);
        rst = 1'b0;
    endtask

    localparam logic [31:0] INST_OR   = 32'h0020E1B3;
    localparam logic [31:0] INST_ADDI = 32'hFFF08093;
    localparam logic [31:0] INST_ILL  = 32'h4020F1B3;
    localparam logic [31:0] INST_SUB  = 32'h40208233;
    localparam logic [31:0] INST_SRAI = 32'h4050D293;

    initial begin
        int n;
        logic [31:0] spc;
        rst = 1'b1; in_valid_i = 1'b0; pc_i = '0; inst_i = '0;
        rs1_data_i = '0; rs2_data_i = '0; out_ready_i = 1'b0;
`ifdef IDU_FLUSH_EN
        flush_drv = 1'b0;
`endif
        init_table();
        do_reset();

        // or x3,x1,x2
        step(1'b1, 32'h100, INST_OR, 32'h0F, 32'hF0, 1'b1, 1'b0);
        chk("or_valid", 32'(out_valid_o), 32'd1);
        chk("or_bit0", 32'(dec_info_bus_o), 32'h1);
        chk("or_rd", 32'(rd_addr_o), 32'd3);
        chk("or_we", 32'(rd_we_o), 32'd1);
        chk("or_rs1", rs1_data_o, 32'h0F);
        chk("or_rs2", rs2_data_o, 32'hF0);

        // addi x1,x1,-1, back-to-back with the or draining
        step(1'b1, 32'h104, INST_ADDI, 32'h7, 32'h8, 1'b1, 1'b0);
        chk("addi_imm", imm_o, 32'hFFFFFFFF);
        chk("addi_bus", 32'(dec_info_bus_o), 32'h80400);
        chk("addi_ill", 32'(illegal_o), 32'd0);

        // Stall three cycles with a second instruction waiting
        xfer_log.delete();
        step(1'b1, 32'h200, INST_SUB, 32'h11, 32'h22, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h204, INST_SRAI, 32'h33, 32'h44, 1'b0, 1'b0);
            chk("stall_ready", 32'(in_ready_o), 32'd0);
            chk("stall_pc", pc_o, 32'h200);
        end
        step(1'b1, 32'h204, INST_SRAI, 32'h33, 32'h44, 1'b1, 1'b0);
        chk("srai_pc", pc_o, 32'h204);
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("drain_valid", 32'(out_valid_o), 32'd0);
        n = 0;
        foreach (xfer_log[k]) if (xfer_log[k] == 32'h204) n++;
        chk("second_once", 32'(n), 32'd1);

        // Illegal OP funct7/funct3 combination
        step(1'b1, 32'h300, INST_ILL, 32'h1, 32'h2, 1'b1, 1'b0);
        chk("ill_flag", 32'(illegal_o), 32'd1);
        chk("ill_we", 32'(rd_we_o), 32'd0);
        chk("ill_dec", 32'(dec_info_bus_o), 32'd0);
        chk("ill_cnt_before", 32'(illegal_cnt_o), 32'd0);
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("ill_cnt_after", 32'(illegal_cnt_o), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic fl;
            fl = 1'b0;
`ifdef IDU_FLUSH_EN
            fl = ($urandom_range(0, 15) == 0);
`endif
            step($urandom_range(0, 3) != 0, $urandom, rand_inst(), $urandom, $urandom,
                 $urandom_range(0, 3) != 0, fl);
        end

        // Reset while a result is stalled discards it
        step(1'b1, 32'h400, INST_OR, 32'h5, 32'h6, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        xfer_log.delete();
        do_reset();
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("rst_discard", 32'(xfer_log.size()), 32'd0);

`ifdef IDU_FLUSH_EN
        // Flush a held illegal result with downstream ready: no count, no accept
        step(1'b1, 32'h500, INST_ILL, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h504, INST_OR, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h508, INST_OR, 32'h0, 32'h0, 1'b1, 1'b1);
        chk("flush_valid", 32'(out_valid_o), 32'd0);
        chk("flush_cnt", 32'(illegal_cnt_o), 32'd0);
`endif

        // Saturation: stream illegal instructions until the counter tops out
        spc = 32'h1000;
        while (m_cnt < 65535) begin
            step(1'b1, spc, INST_ILL, 32'h0, 32'h0, 1'b1, 1'b0);
            spc = spc + 32'd4;
        end
        chk("sat_reach", 32'(illegal_cnt_o), 32'hFFFF);
        step(1'b1, spc, INST_ILL, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("sat_hold", 32'(illegal_cnt_o), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
